// File: rtl/loss.sv
// ---------------------------------------------------------------------------
// loss
//   Computes the signed error between one 8-bit activation and one 8-bit
//   target label. The error is err_dat = (res - tgt) << SCALE, given as a
//   sign-extended Q8.8 value. The block also keeps running statistics of
//   completed samples.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   res_stb/rdy/dat   activation input handshake, unsigned Q0.8
//   tgt_stb/rdy/dat   target input handshake, unsigned Q0.8
//   err_stb/rdy/dat   error output handshake, signed Q8.8
//   clr               synchronous clear of cnt/sae
//   cnt               samples completed (saturating at 0xFFFF)
//   sae               sum of |res - tgt|, unscaled (saturating at all-ones)
//
//   state | meaning
//   ------+---------------------------------------------------------
//   WAIT  | collecting operands; each side captured independently
//   CALC  | both operands held; error computed on the exit edge
//   ERR   | error presented; leaves on consumer acceptance
// ---------------------------------------------------------------------------
module loss #(
    parameter int SCALE      = 0,
    parameter int STAT_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  res_stb,
    input  logic [7:0]            res_dat,
    output logic                  res_rdy,
    input  logic                  tgt_stb,
    input  logic [7:0]            tgt_dat,
    output logic                  tgt_rdy,
    output logic                  err_stb,
    output logic [15:0]           err_dat,
    input  logic                  err_rdy,
    input  logic                  clr,
    output logic [15:0]           cnt,
    output logic [STAT_WIDTH-1:0] sae
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_CALC = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_res_vld;
    logic                  r_tgt_vld;
    logic [7:0]            r_res;
    logic [7:0]            r_tgt;
    logic [7:0]            r_abs;
    logic                  r_err_stb;
    logic [15:0]           r_err_dat;
    logic [15:0]           r_cnt;
    logic [STAT_WIDTH-1:0] r_sae;

    logic                  w_res_xfer;
    logic                  w_tgt_xfer;
    logic                  w_err_ack;
    logic [8:0]            w_diff;
    logic [7:0]            w_abs;
    logic signed [15:0]    w_diff_ext;
    logic signed [15:0]    w_err_scaled;
    logic [STAT_WIDTH:0]   w_sae_sum;

    assign res_rdy = (r_state == S_WAIT) && !r_res_vld;
    assign tgt_rdy = (r_state == S_WAIT) && !r_tgt_vld;
    assign err_stb = r_err_stb;
    assign err_dat = r_err_dat;
    assign cnt     = r_cnt;
    assign sae     = r_sae;

    assign w_res_xfer = res_stb && res_rdy;
    assign w_tgt_xfer = tgt_stb && tgt_rdy;
    assign w_err_ack  = r_err_stb && err_rdy;

    // The 9-bit two's-complement difference covers -255..255 exactly.
    // Shifting it left by up to 7 places still fits in 16 bits, so the
    // result never needs saturation.
    assign w_diff       = {1'b0, r_res} - {1'b0, r_tgt};
    assign w_abs        = w_diff[8] ? (~w_diff[7:0] + 8'd1) : w_diff[7:0];
    assign w_diff_ext   = {{7{w_diff[8]}}, w_diff};
    assign w_err_scaled = w_diff_ext <<< SCALE;

    // The spare top bit catches the carry out, which means the sum saturates.
    assign w_sae_sum = {1'b0, r_sae} + (STAT_WIDTH+1)'(r_abs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_WAIT;
            r_res_vld <= 1'b0;
            r_tgt_vld <= 1'b0;
            r_res     <= 8'd0;
            r_tgt     <= 8'd0;
            r_abs     <= 8'd0;
            r_err_stb <= 1'b0;
            r_err_dat <= 16'd0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_res_xfer) begin
                        r_res     <= res_dat;
                        r_res_vld <= 1'b1;
                    end
                    if (w_tgt_xfer) begin
                        r_tgt     <= tgt_dat;
                        r_tgt_vld <= 1'b1;
                    end
                    if ((r_res_vld || w_res_xfer) && (r_tgt_vld || w_tgt_xfer))
                        r_state <= S_CALC;
                end
                S_CALC: begin
                    r_err_dat <= w_err_scaled;
                    r_abs     <= w_abs;
                    r_err_stb <= 1'b1;
                    r_state   <= S_ERR;
                end
                S_ERR: begin
                    if (err_rdy) begin
                        r_err_stb <= 1'b0;
                        r_res_vld <= 1'b0;
                        r_tgt_vld <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                default: begin
                    r_err_stb <= 1'b0;
                    r_res_vld <= 1'b0;
                    r_tgt_vld <= 1'b0;
                    r_state   <= S_WAIT;
                end
            endcase
        end
    end

    // When clr and acceptance land on the same edge, clr wins and the
    // sample is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
            r_sae <= '0;
        end else if (clr) begin
            r_cnt <= 16'd0;
            r_sae <= '0;
        end else if (w_err_ack) begin
            if (r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
            r_sae <= w_sae_sum[STAT_WIDTH] ? '1 : w_sae_sum[STAT_WIDTH-1:0];
        end
    end

endmodule
